// File: rtl/mode_pkg.sv
// Shared types and constants for the mode sequencer: FSM state encoding,
// default routing masks and the names of the four legacy modes.
package mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  localparam logic [3:0] SEQ_MODES_DEF  = 4'b1001;
  localparam logic [3:0] LIVE_MODES_DEF = 4'b0010;

  localparam int MODE_BOX       = 0;
  localparam int MODE_ELECTONE  = 1;
  localparam int MODE_WRITE     = 2;
  localparam int MODE_WRITE_BOX = 3;

endpackage

// File: rtl/mode_next_sel.sv
// Wrap-around priority scan for the next (or previous) selectable mode,
// never returning the current mode itself.
module mode_next_sel
  import mode_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic [MODE_W-1:0]    mode,
  input  logic [NUM_MODES-1:0] mode_mask,
  input  logic                 dir_prev,
  output logic [MODE_W-1:0]    target,
  output logic                 found
);

  always_comb begin
    int cur;
    int cand;
    target = mode;
    found  = 1'b0;
    cur    = int'(mode);
    // Walk from the farthest distance inward so the nearest hit is the last write.
    for (int i = NUM_MODES - 1; i >= 1; i--) begin
      cand = dir_prev ? ((cur + NUM_MODES - i) % NUM_MODES) : ((cur + i) % NUM_MODES);
      if (mode_mask[cand]) begin
        target = MODE_W'(cand);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode controller: steps a mode index under a selectable mask, drains the
// active playback path before each switch and routes keys/buttons per mode.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int                   NUM_MODES    = 4,
  parameter int                   MODE_W       = $clog2(NUM_MODES),
  parameter int                   KEY_W        = 16,
  parameter logic [NUM_MODES-1:0] SEQ_MODES    = NUM_MODES'(SEQ_MODES_DEF),
  parameter logic [NUM_MODES-1:0] LIVE_MODES   = NUM_MODES'(LIVE_MODES_DEF),
  parameter int                   TIMEOUT      = 1024,
  parameter int                   DEFAULT_MODE = MODE_BOX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_next,
  input  logic                 mode_prev,
  input  logic [NUM_MODES-1:0] mode_mask,
  input  logic                 idle_ack,
  input  logic [KEY_W-1:0]     key_sw,
  input  logic [KEY_W-1:0]     key_seq,
  input  logic                 btn_inc,
  input  logic                 btn_dec,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 quiesce_req,
  output logic                 switch_done,
  output logic                 timed_out,
  output logic [KEY_W-1:0]     key_out,
  output logic                 trk_next,
  output logic                 trk_prev,
  output logic                 vol_up,
  output logic                 vol_dn,
  output logic                 busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                 state, next_state;
  logic [MODE_W-1:0]      mode_p0;
  logic [NUM_MODES-1:0]   onehot_p0;
  logic [MODE_W-1:0]      target_p0;
  logic [CNT_W-1:0]       cnt_p0;
  logic                   timed_out_p0;
  logic [MODE_W-1:0]      sel_target;
  logic                   sel_found;
  logic                   start;
  logic                   drain_exit;
  logic [KEY_W-1:0]       key_p1;
  logic                   trk_next_p1, trk_prev_p1, vol_up_p1, vol_dn_p1;
  logic                   route_en;
  logic                   is_seq, is_live;

  mode_next_sel #(
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_sel (
    .mode      (mode_p0),
    .mode_mask (mode_mask),
    .dir_prev  (mode_prev),
    .target    (sel_target),
    .found     (sel_found)
  );

  always_comb begin
    next_state = state;
    start      = 1'b0;
    drain_exit = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((mode_next ^ mode_prev) && sel_found) begin
          start      = 1'b1;
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (idle_ack || (cnt_p0 == CNT_LAST)) begin
          drain_exit = 1'b1;
          next_state = ST_SWITCH;
        end
      end
      ST_SWITCH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Stage p0: mode index, drain target and timeout bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0      <= MODE_W'(DEFAULT_MODE);
      onehot_p0    <= NUM_MODES'(1) << DEFAULT_MODE;
      target_p0    <= '0;
      cnt_p0       <= '0;
      timed_out_p0 <= 1'b0;
    end else begin
      if (start) begin
        target_p0 <= sel_target;
        cnt_p0    <= '0;
      end else if (state == ST_DRAIN) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (drain_exit) begin
        mode_p0      <= target_p0;
        onehot_p0    <= NUM_MODES'(1) << target_p0;
        timed_out_p0 <= ~idle_ack;
      end
    end
  end

  // Route by the mode that will be in force next cycle; silent unless returning to IDLE.
  assign route_en = (next_state == ST_IDLE);
  assign is_seq   = SEQ_MODES[mode_p0];
  assign is_live  = LIVE_MODES[mode_p0];

  function automatic logic [KEY_W-1:0] route_key(input logic en, input logic seq,
                                                 input logic live,
                                                 input logic [KEY_W-1:0] kseq,
                                                 input logic [KEY_W-1:0] ksw);
    if (!en)       return '0;
    else if (seq)  return kseq;
    else if (live) return ksw;
    else           return '0;
  endfunction

  // Stage p1: registered routed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p1      <= '0;
      trk_next_p1 <= 1'b0;
      trk_prev_p1 <= 1'b0;
      vol_up_p1   <= 1'b0;
      vol_dn_p1   <= 1'b0;
    end else begin
      key_p1      <= route_key(route_en, is_seq, is_live, key_seq, key_sw);
      trk_next_p1 <= route_en & is_seq  & btn_inc;
      trk_prev_p1 <= route_en & is_seq  & btn_dec;
      vol_up_p1   <= route_en & is_live & btn_inc;
      vol_dn_p1   <= route_en & is_live & btn_dec;
    end
  end

  assign mode        = mode_p0;
  assign mode_onehot = onehot_p0;
  assign quiesce_req = (state == ST_DRAIN);
  assign switch_done = (state == ST_SWITCH);
  assign timed_out   = (state == ST_SWITCH) & timed_out_p0;
  assign busy        = (state != ST_IDLE);
  assign key_out     = key_p1;
  assign trk_next    = trk_next_p1;
  assign trk_prev    = trk_prev_p1;
  assign vol_up      = vol_up_p1;
  assign vol_dn      = vol_dn_p1;

endmodule
